// File: rtl/proj_feeder.sv
// Fetches one feature vector from the ping-pong input buffer and streams it
// to the projection unit as NUM_BEATS valid/ready beats of CHUNK elements.
module proj_feeder #(
    parameter int HIDDEN_SIZE = 768,
    parameter int BITWIDTH    = 4,
    parameter int CHUNK       = 32,
    parameter int TIMEOUT     = 15,
    localparam int NUM_BEATS  = HIDDEN_SIZE / CHUNK,
    localparam int IDX_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            proj_req,
    input  logic [HIDDEN_SIZE*BITWIDTH-1:0] buf_data,
    input  logic                            buf_ready,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [CHUNK*BITWIDTH-1:0]       m_data,
    output logic [IDX_W-1:0]                m_idx,
    output logic                            m_last,
    output logic                            busy,
    output logic                            done,
    output logic                            err_timeout
);

    localparam int BEAT_W = CHUNK * BITWIDTH;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, STREAM} state_t;

    state_t                          state_q, state_d;
    // Beat-major view of the captured vector: element 0 sits in beat 0 LSBs.
    logic [NUM_BEATS-1:0][BEAT_W-1:0] vec_q;
    logic [IDX_W-1:0]                beat_q, beat_d;
    logic [TMO_W-1:0]                tmo_q, tmo_d;
    logic                            capture;
    logic                            done_q, done_d;
    logic                            err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (capture)
                vec_q <= buf_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        tmo_d    = tmo_q;
        capture  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        proj_req = 1'b0;
        m_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = REQ;
            end
            REQ: begin
                proj_req = 1'b1;
                tmo_d    = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (buf_ready) begin
                    capture = 1'b1;
                    beat_d  = '0;
                    state_d = STREAM;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            STREAM: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    if (beat_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_idx       = m_valid ? beat_q : '0;
    assign m_data      = m_valid ? vec_q[beat_q] : '0;
    assign m_last      = m_valid && (beat_q == LAST_IDX);
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_proj_feeder.sv
// Directed bench for proj_feeder: cycle table for fetch/stall behaviour plus
// hand sequences for full streams, timeout, async reset and back-to-back starts.
module tb_proj_feeder;

    localparam int HS = 768;
    localparam int BW = 4;
    localparam int CH = 32;
    localparam int NB = 24;
    localparam int DW = CH * BW;
    localparam int IW = 5;
    localparam int VW = HS * BW;
    localparam int OW = 6 + IW + DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          buf_ready = 1'b0;
    logic          m_ready = 1'b0;
    logic [VW-1:0] buf_data = '0;
    logic          proj_req, m_valid, m_last, busy, done, err_timeout;
    logic [DW-1:0] m_data;
    logic [IW-1:0] m_idx;

    int n_pass = 0;
    int n_tot  = 0;

    proj_feeder #(
        .HIDDEN_SIZE(HS),
        .BITWIDTH   (BW),
        .CHUNK      (CH),
        .TIMEOUT    (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .proj_req   (proj_req),
        .buf_data   (buf_data),
        .buf_ready  (buf_ready),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_idx      (m_idx),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Element value of buffer pattern pat at element position i.
    function automatic logic [BW-1:0] elem(input int pat, input int i);
        int e;
        case (pat)
            0:       e = i % 16;
            1:       e = (i * 7 + 3) % 16;
            default: e = 15 - (i % 16);
        endcase
        return e[BW-1:0];
    endfunction

    function automatic logic [VW-1:0] make_vec(input int pat);
        logic [VW-1:0] v;
        for (int i = 0; i < HS; i++)
            v[i*BW +: BW] = elem(pat, i);
        return v;
    endfunction

    function automatic logic [DW-1:0] beat_of(input int pat, input int k);
        logic [DW-1:0] r;
        for (int j = 0; j < CH; j++)
            r[j*BW +: BW] = elem(pat, CH * k + j);
        return r;
    endfunction

    function automatic logic [OW-1:0] expv(input logic req, input logic mv, input logic last,
                                           input logic bsy, input logic dn, input logic err,
                                           input int idx, input logic [DW-1:0] d);
        logic [IW-1:0] i5;
        i5 = IW'(idx);
        return {req, mv, last, bsy, dn, err, i5, d};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {proj_req, m_valid, m_last, busy, done, err_timeout, m_idx, m_data};
    endfunction

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a start and answer the request one cycle later; leaves the DUT
    // at its first STREAM cycle. hold keeps start and buf_ready asserted.
    task automatic fetch(input int pat, input bit hold);
        start = 1'b1;
        step();
        chk("fetch_req", obs(), expv(1, 0, 0, 1, 0, 0, 0, '0));
        start     = hold;
        buf_data  = make_vec(pat);
        buf_ready = 1'b1;
        step();
        chk("fetch_wait", obs(), expv(0, 0, 0, 1, 0, 0, 0, '0));
        step();
        if (!hold) buf_ready = 1'b0;
    endtask

    // Consume beats from first onwards; checks every cycle, the number of
    // valid cycles, and the done pulse after the final handshake.
    task automatic stream_check(input int pat, input bit toggle, input int first, input int exp_cyc);
        int beat;
        int cyc;
        beat = first;
        cyc  = 0;
        while (beat < NB && cyc < 200) begin
            m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            chk($sformatf("p%0d_beat%0d_c%0d", pat, beat, cyc), obs(),
                expv(0, 1, beat == NB - 1, 1, 0, 0, beat, beat_of(pat, beat)));
            step();
            if (m_ready) beat++;
            cyc++;
        end
        m_ready = 1'b0;
        chk_int($sformatf("p%0d_stream_cycles", pat), cyc, exp_cyc);
        chk($sformatf("p%0d_done", pat), obs(), expv(0, 0, 0, 0, 1, 0, 0, '0));
    endtask

    typedef struct {
        logic start, br, mr;
        logic e_req, e_mv, e_last, e_busy, e_done;
        int   e_idx;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3};

        #12;
        chk("reset_state", obs(), '0);
        #5 rst_n = 1'b1;
        step();
        chk("idle_after_reset", obs(), '0);

        // Cycle table: fetch, stalls, start ignored and buf_ready ignored mid-stream.
        buf_data = make_vec(0);
        for (int i = 0; i < 8; i++) begin
            start     = tbl[i].start;
            buf_ready = tbl[i].br;
            m_ready   = tbl[i].mr;
            step();
            chk($sformatf("vec%0d", i), obs(),
                expv(tbl[i].e_req, tbl[i].e_mv, tbl[i].e_last, tbl[i].e_busy, tbl[i].e_done, 1'b0,
                     tbl[i].e_idx, tbl[i].e_mv ? beat_of(0, tbl[i].e_idx) : '0));
            if (i == 2) buf_data = make_vec(1);
        end
        start = 1'b0; buf_ready = 1'b0;
        stream_check(0, 1'b0, 3, 21);
        step();
        chk("done_one_cycle", obs(), '0);

        // Full stream with m_ready held high.
        fetch(0, 1'b0);
        stream_check(0, 1'b0, 0, 24);
        step();
        chk("idle_after_stream", obs(), '0);

        // m_ready alternating 1/0.
        fetch(1, 1'b0);
        stream_check(1, 1'b1, 0, 47);
        step();
        chk("idle_after_toggle", obs(), '0);

        // Buffer never responds.
        start = 1'b1;
        step();
        chk("tmo_req", obs(), expv(1, 0, 0, 1, 0, 0, 0, '0));
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("tmo_wait%0d", i), obs(), expv(0, 0, 0, 1, 0, 0, 0, '0));
        end
        step();
        chk("tmo_pulse", obs(), expv(0, 0, 0, 0, 0, 1, 0, '0));
        step();
        chk("tmo_after", obs(), '0);

        // Asynchronous reset while beat 10 is presented.
        fetch(0, 1'b0);
        m_ready = 1'b1;
        repeat (10) step();
        chk("pre_reset_beat10", obs(), expv(0, 1, 0, 1, 0, 0, 10, beat_of(0, 10)));
        m_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("async_reset", obs(), '0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_reset%0d", i), obs(), '0);
        end
        fetch(2, 1'b0);
        stream_check(2, 1'b0, 0, 24);
        step();
        chk("idle_after_reset_stream", obs(), '0);

        // start held high across two vectors; buf_ready stays high mid-stream.
        fetch(0, 1'b1);
        buf_data = make_vec(1);
        stream_check(0, 1'b0, 0, 24);
        fetch(1, 1'b1);
        buf_data = make_vec(2);
        stream_check(1, 1'b0, 0, 24);
        start = 1'b0; buf_ready = 1'b0;
        step();
        chk("idle_final", obs(), '0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
